// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared CIC defaults, FSM state encodings and width helper
//
// Purpose: constants shared by the Comb and the upsampling integrator halves
// of the CIC interpolator, plus a clog2 helper for counter sizing.
// Ports: none (package).

package cic_pkg;

   // Default geometry; the Comb and integrator halves must agree on these.
   localparam int CIC_N_STAGES   = 3;
   localparam int CIC_R          = 4;
   localparam int CIC_IN_W       = 32;
   localparam int CIC_OUT_W      = 40;
   localparam int CIC_GAIN_SHIFT = 4;

   // Upsampler FSM encodings.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Bits needed to count 0..value-1. The result is never below 1, so a
   // ratio of 1 still yields a legal (unused) counter.
   function automatic int cic_clog2(input int value);
      int w;
      w = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         w++;
      end
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// rtl/cic_integrator_stage.sv - one pipelined CIC integrator with its valid bit
//
// Purpose: a single accumulator of the high-rate integrator chain. When the
// pipeline advances, the valid bit shifts along, and the accumulator adds
// x_in only when the incoming sample is valid.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset
//   en     in   pipeline advance; nothing changes when low
//   v_in   in   x_in carries a real slot this cycle
//   x_in   in   W-bit signed addend (previous stage's registered acc)
//   v_out  out  registered valid, aligned with acc
//   acc    out  W-bit signed accumulator, wraps modulo 2^W

module cic_integrator_stage #(
   parameter int W = 40
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                v_in,
   input  logic signed [W-1:0] x_in,
   output logic                v_out,
   output logic signed [W-1:0] acc
);

   logic                v_q;
   logic signed [W-1:0] acc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q   <= 1'b0;
         acc_q <= '0;
      end else if (en) begin
         v_q <= v_in;
         // Wrapping is intentional: the end-to-end CIC result stays exact.
         if (v_in) begin
            acc_q <= acc_q + x_in;
         end
      end
   end

   assign v_out = v_q;
   assign acc   = acc_q;

endmodule

// File: rtl/cic_upsample_integrator.sv
// rtl/cic_upsample_integrator.sv - CIC interpolator zero-stuffer plus integrator chain
//
// Purpose: back half of the CIC interpolator. Each accepted comb sample is
// issued as one slot followed by R-1 zero slots, and every slot runs through
// N_STAGES pipelined integrators. Valid/ready on both sides; a stalled sink
// freezes the whole block.
// Optional feature macro: CIC_GAIN_NORM_EN -- when defined, d_out is the last
// accumulator arithmetically shifted right by GAIN_SHIFT; otherwise it is raw.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   d_in       in   IN_W signed comb sample
//   in_valid   in   d_in valid
//   in_ready   out  d_in accepted this cycle (only in IDLE while advancing)
//   d_out      out  OUT_W signed interpolated sample
//   out_valid  out  d_out valid
//   out_ready  in   sink accepts d_out

module cic_upsample_integrator
   import cic_pkg::*;
#(
   parameter int N_STAGES   = CIC_N_STAGES,
   parameter int R          = CIC_R,
   parameter int IN_W       = CIC_IN_W,
   parameter int OUT_W      = CIC_OUT_W,
   parameter int GAIN_SHIFT = CIC_GAIN_SHIFT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  d_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [OUT_W-1:0] d_out,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int PH_W = cic_clog2(R);

   if (N_STAGES < 1 || R < 1 || OUT_W < IN_W || GAIN_SHIFT < 0 || GAIN_SHIFT >= OUT_W) begin : g_bad_param
      $error("cic_upsample_integrator: illegal parameter combination");
   end

   logic [0:0]              state_q, state_d;
   logic [PH_W-1:0]         phase_q, phase_d;
   logic                    advance;
   logic                    issue;
   logic signed [OUT_W-1:0] slot;

   // Element 0 is the issue point; element i is the output of stage i.
   logic [N_STAGES:0]            v_chain;
   logic [N_STAGES:0][OUT_W-1:0] x_chain;
   logic signed [OUT_W-1:0]      acc_n;

   assign advance  = !out_valid || out_ready;
   // Gated by rst so the port reads 0 throughout reset even though advance
   // is combinationally high then.
   assign in_ready = rst && (state_q == ST_IDLE) && advance;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      issue   = 1'b0;
      slot    = '0;
      if (advance) begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  issue = 1'b1;
                  slot  = OUT_W'($signed(d_in));
                  if (R > 1) begin
                     state_d = ST_RUN;
                     phase_d = PH_W'(1);
                  end
               end
            end
            default: begin
               // Zero-stuffing: the last zero returns to IDLE.
               issue = 1'b1;
               if (phase_q == PH_W'(R - 1)) begin
                  state_d = ST_IDLE;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + PH_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   assign v_chain[0] = issue;
   assign x_chain[0] = slot;

   for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
      cic_integrator_stage #(
         .W (OUT_W)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .en    (advance),
         .v_in  (v_chain[i]),
         .x_in  (x_chain[i]),
         .v_out (v_chain[i+1]),
         .acc   (x_chain[i+1])
      );
   end

   assign acc_n     = x_chain[N_STAGES];
   assign out_valid = v_chain[N_STAGES];

`ifdef CIC_GAIN_NORM_EN
   // Arithmetic shift on a signed operand: floor division, sign preserved.
   assign d_out = acc_n >>> GAIN_SHIFT;
`else
   assign d_out = acc_n;
`endif

endmodule

// File: tb/tb_cic_upsample_integrator.sv
// tb/tb_cic_upsample_integrator.sv - self-checking bench for cic_upsample_integrator

module tb_cic_upsample_integrator;

   localparam int N     = 3;
   localparam int R     = 4;
   localparam int IN_W  = 32;
   localparam int OUT_W = 40;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic signed [IN_W-1:0]  d_in;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [OUT_W-1:0] d_out;
   logic                    out_valid;
   logic                    out_ready;

   int checks = 0;
   int errors = 0;

   // Reference: the integrator cascade as running sums over the zero-stuffed stream.
   logic signed [OUT_W-1:0] c1, c2, c3;
   logic signed [OUT_W-1:0] exp_q[$];
   logic signed [OUT_W-1:0] got_q[$];
   int                      acc_cyc_q[$];
   int                      cyc = 0;
   int                      first_val_cyc = -1;
   logic signed [OUT_W-1:0] held;
   int                      tri_tab[6]  = '{1, 3, 6, 10, 15, 21};
   int                      step_tab[9] = '{1, 3, 6, 10, 16, 24, 34, 46, 61};
   int                      n_acc;

   always #5 clk = ~clk;

   cic_upsample_integrator #(
      .N_STAGES   (N),
      .R          (R),
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .GAIN_SHIFT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .d_in      (d_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d_out     (d_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_accept(input logic signed [IN_W-1:0] d);
      logic signed [OUT_W-1:0] x;
      for (int k = 0; k < R; k++) begin
         x  = (k == 0) ? OUT_W'(d) : '0;
         c1 = c1 + x;
         c2 = c2 + c1;
         c3 = c3 + c2;
         exp_q.push_back(c3);
      end
      acc_cyc_q.push_back(cyc);
   endtask

   task automatic clear_model();
      c1 = '0;
      c2 = '0;
      c3 = '0;
      exp_q.delete();
      got_q.delete();
      acc_cyc_q.delete();
      first_val_cyc = -1;
   endtask

   // Observe on the falling edge, then return 1 time unit after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (rst && in_valid && in_ready) model_accept(d_in);
      if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (out_valid && out_ready) begin
         got_q.push_back(d_out);
         if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
         else check("scoreboard", d_out, exp_q.pop_front());
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_model();
   endtask

   initial begin
      d_in      = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_d_out", d_out, 0);
      check("rst_in_ready", in_ready, 0);
      rst = 1'b1;

      // Impulse: triangular numbers, latency N edges.
      d_in = 1; in_valid = 1'b1;
      tick();
      d_in = 0;
      repeat (7) tick();
      drain();
      check("impulse_latency", first_val_cyc - acc_cyc_q[0], N);
      for (int i = 0; i < 6; i++) check("impulse_val", got_q[i], tri_tab[i]);

      // Step with sustained input, then a 5-cycle stall.
      do_reset();
      d_in = 1; in_valid = 1'b1;
      repeat (40) tick();
      for (int i = 0; i < 9; i++) check("step_val", got_q[i], step_tab[i]);
      for (int i = 1; i < acc_cyc_q.size(); i++) check("step_cadence", acc_cyc_q[i] - acc_cyc_q[i-1], R);
      held = d_out;
      out_ready = 1'b0;
      repeat (5) begin
         tick();
         check("bp_valid", out_valid, 1);
         check("bp_hold", d_out, held);
      end
      out_ready = 1'b1;
      repeat (20) tick();
      drain();

      // Gapped input: three idle cycles between samples, same values as gapless.
      do_reset();
      d_in = 1;
      for (int s = 0; s < 4; s++) begin
         n_acc = acc_cyc_q.size();
         in_valid = 1'b1;
         for (int i = 0; i < 20 && acc_cyc_q.size() == n_acc; i++) tick();
         check("gap_accept", acc_cyc_q.size(), n_acc + 1);
         in_valid = 1'b0;
         repeat (R - 1 + 3) tick();
      end
      drain();
      for (int i = 0; i < 9; i++) check("gap_val", got_q[i], step_tab[i]);
      check("gap_count", got_q.size(), 4 * R);

      // Random data, random input gaps and random sink stalls.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         d_in      = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      // Asynchronous reset in the middle of RUN, while a valid output is held.
      do_reset();
      d_in = 1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; d_in = 0;
      repeat (2) tick();
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_d_out", d_out, 0);
      check("mid_rst_in_ready", in_ready, 0);
      clear_model();
      @(posedge clk);
      #1;
      rst = 1'b1;
      d_in = 1; in_valid = 1'b1;
      tick();
      d_in = 0;
      repeat (7) tick();
      drain();
      for (int i = 0; i < 6; i++) check("post_rst_impulse", got_q[i], tri_tab[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
